alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Decode-side producer for the execute-stage ALU. Takes a decoded RV32I instruction plus register-file operands from ID and generates the ALU operand pair, the 4-bit ALU control code and the writeback tags.
- Buffers them in a 2-entry valid/ready skid buffer that drives the EX stage.
- Sits between the register-file read and the ALU. It is the encoder end of the ALU control interface.

Parameters:
- XLEN, 32, operand/data width
- RD_W, 5, destination register index width

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  ID presents an instruction
- in_ready  output  1  stage can accept this cycle
- in_instr  input  32  raw instruction word
- in_pc  input  XLEN  instruction PC
- in_rs1  input  XLEN  rs1 value (already forwarded)
- in_rs2  input  XLEN  rs2 value (already forwarded)
- in_imm  input  XLEN  sign-extended immediate from immediate generator
- flush  input  1  kill all buffered entries (taken branch/jump)
- ex_valid  output  1  EX entry valid
- ex_ready  input  1  EX consumes entry
- ex_a  output  XLEN  ALU operand A
- ex_b  output  XLEN  ALU operand B
- ex_alu_ctrl  output  4  ALU control code
- ex_is_branch  output  1  entry is a conditional branch
- ex_rd  output  RD_W  destination register
- ex_reg_write  output  1  writeback enable
- ex_illegal  output  1  unsupported opcode/funct

Behaviour:
- ALU codes:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1110, SLTU 1111.
  - BLT 1000, BGE 1001, BLTU 1010, BGEU 1011, BEQ 1100, BNE 1101.
- R-type (0110011): funct3/funct7[5] select the code; a=rs1, b=rs2. SUB and SRA need funct7[5]=1. Any other funct7 value sets illegal.
- I-ALU (0010011): a=rs1, b=imm. SRAI uses imm[10]=1. SLLI/SRLI/SRAI force b={27'b0, imm[4:0]}.
- Shift masking: for R-type shifts, b={27'b0, rs2[4:0]}. The ALU shifts by the full B operand, so masking here is mandatory.
- LUI: a=0, b=imm, ADD. AUIPC: a=pc, b=imm, ADD.
- Load/store: a=rs1, b=imm, ADD. reg_write=1 for loads only.
- Branch (1100011): a=rs1, b=rs2, branch code from funct3, is_branch=1, reg_write=0. funct3 010/011 is illegal.
- Unknown opcode: illegal=1, reg_write=0, code 0000.
- Decode is combinational on the in_* ports. The result is captured on the accept edge.
- Buffer FSM: EMPTY, ONE, TWO.
  - Accept = in_valid & in_ready. Drain = ex_valid & ex_ready.
  - EMPTY --accept--> ONE.
  - ONE: accept&~drain -> TWO. drain&~accept -> EMPTY. Both -> stays ONE, new entry replaces head.
  - TWO: drain -> ONE, skid entry moves to head. No accept is possible in TWO.
- in_ready = (state != TWO). It is a registered-state function only, with no combinational path from ex_ready.
- ex_valid = (state != EMPTY). The ex_* outputs come directly from the head register.
- Latency: 1 cycle from accept to ex_valid when empty.
- flush: next state EMPTY. Any accept in the same cycle is discarded. flush has priority over every event.
- Reset (async, rst_n=0): state EMPTY, ex_valid=0, all ex_* data outputs 0, in_ready=0 while reset is asserted. in_ready returns to 1 on the first clock after release.
- Reset asserted mid-operation drops both entries without handshake.
- Outputs are stable while ex_valid=1 and ex_ready=0.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN.
- Defined: adds outputs perf_issued[31:0] (increments per drain) and perf_stall[31:0] (increments per cycle with ex_valid & ~ex_ready). Both wrap at 2^32 and are cleared by reset and not by flush.
- Undefined: ports and counters are absent, with no other change.

Decomposition:
- Shared package alu_pkg:
  - 4-bit ALU code localparams, used by the ALU too.
  - Opcode constants.
  - Buffer state encoding.
- Sub-module alu_ctrl_decode: pure combinational instruction -> {a_sel, b_sel, code, is_branch, reg_write, illegal}.
- The top holds operand muxing and the skid FSM.

Test Plan:
- add x3,x1,x2 with rs1=5, rs2=7, ex_ready=1 -> next cycle ex_valid=1, a=5, b=7, ctrl=0000, reg_write=1.
- sub, then sra with rs2=0x00000023 -> ctrl 0001, then 1110 with b=0x00000003.
- bgeu with rs1=0xFFFFFFFF, rs2=1 -> ctrl 1011, is_branch=1, reg_write=0. funct3=010 branch -> illegal=1.
- ex_ready=0 with three back-to-back in_valid -> two accepted, in_ready=0 after the second, head held stable. Raising ex_ready drains both in order.
- flush in state TWO coincident with in_valid -> next cycle ex_valid=0, in_ready=1, nothing issued.
- rst_n pulled low asynchronously in state ONE -> ex_valid=0 immediately. With ALU_ISSUE_PERF_EN, counters read 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control codes, RV32I opcodes and issue-buffer state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1110;
    localparam logic [3:0] ALU_SLTU = 4'b1111;
    localparam logic [3:0] ALU_BLT  = 4'b1000;
    localparam logic [3:0] ALU_BGE  = 4'b1001;
    localparam logic [3:0] ALU_BLTU = 4'b1010;
    localparam logic [3:0] ALU_BGEU = 4'b1011;
    localparam logic [3:0] ALU_BEQ  = 4'b1100;
    localparam logic [3:0] ALU_BNE  = 4'b1101;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
    typedef enum logic [1:0] {B_RS2, B_IMM, B_RS2_SH, B_IMM_SH} b_sel_e;

    typedef struct packed {
        a_sel_e     a_sel;
        b_sel_e     b_sel;
        logic [3:0] code;
        logic       is_branch;
        logic       reg_write;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I instruction fields -> ALU operand selects, control code and tags.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output dec_t       dec_c
);

    always_comb begin
        dec_c = '{a_sel: A_RS1, b_sel: B_RS2, code: ALU_ADD,
                  is_branch: 1'b0, reg_write: 1'b0, illegal: 1'b0};
        case (opcode)
            OP_R: begin
                dec_c.reg_write = 1'b1;
                case (funct3)
                    3'b000: dec_c.code = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001: begin dec_c.code = ALU_SLL; dec_c.b_sel = B_RS2_SH; end
                    3'b010: dec_c.code = ALU_SLT;
                    3'b011: dec_c.code = ALU_SLTU;
                    3'b100: dec_c.code = ALU_XOR;
                    3'b101: begin
                        dec_c.code  = funct7[5] ? ALU_SRA : ALU_SRL;
                        dec_c.b_sel = B_RS2_SH;
                    end
                    3'b110: dec_c.code = ALU_OR;
                    default: dec_c.code = ALU_AND;
                endcase
                if (funct7 != 7'b0000000 &&
                    !(funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
                    dec_c.illegal = 1'b1;
            end
            OP_I: begin
                dec_c.reg_write = 1'b1;
                dec_c.b_sel     = B_IMM;
                case (funct3)
                    3'b000: dec_c.code = ALU_ADD;
                    3'b001: begin
                        dec_c.code  = ALU_SLL;
                        dec_c.b_sel = B_IMM_SH;
                        if (funct7 != 7'b0000000) dec_c.illegal = 1'b1;
                    end
                    3'b010: dec_c.code = ALU_SLT;
                    3'b011: dec_c.code = ALU_SLTU;
                    3'b100: dec_c.code = ALU_XOR;
                    3'b101: begin
                        // funct7[5] is imm[10], the SRAI selector
                        dec_c.code  = funct7[5] ? ALU_SRA : ALU_SRL;
                        dec_c.b_sel = B_IMM_SH;
                        if (funct7 != 7'b0000000 && funct7 != 7'b0100000) dec_c.illegal = 1'b1;
                    end
                    3'b110: dec_c.code = ALU_OR;
                    default: dec_c.code = ALU_AND;
                endcase
            end
            OP_LUI: begin
                dec_c.a_sel     = A_ZERO;
                dec_c.b_sel     = B_IMM;
                dec_c.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                dec_c.a_sel     = A_PC;
                dec_c.b_sel     = B_IMM;
                dec_c.reg_write = 1'b1;
            end
            OP_LOAD: begin
                dec_c.b_sel     = B_IMM;
                dec_c.reg_write = 1'b1;
            end
            OP_STORE: dec_c.b_sel = B_IMM;
            OP_BRANCH: begin
                dec_c.is_branch = 1'b1;
                case (funct3)
                    3'b000: dec_c.code = ALU_BEQ;
                    3'b001: dec_c.code = ALU_BNE;
                    3'b100: dec_c.code = ALU_BLT;
                    3'b101: dec_c.code = ALU_BGE;
                    3'b110: dec_c.code = ALU_BLTU;
                    3'b111: dec_c.code = ALU_BGEU;
                    default: dec_c.illegal = 1'b1;
                endcase
            end
            default: dec_c.illegal = 1'b1;
        endcase
        // Illegal entries must never write back or resolve as a branch
        if (dec_c.illegal) begin
            dec_c.code      = ALU_ADD;
            dec_c.is_branch = 1'b0;
            dec_c.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode + operand mux feeding a 2-entry skid buffer toward EX.
// Optional macro ALU_ISSUE_PERF_EN adds issued/stall performance counters.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [3:0]      ex_alu_ctrl,
    output logic            ex_is_branch,
    output logic [RD_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_illegal
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_stall
`endif
);

    localparam int unsigned ENT_W = 2 * XLEN + RD_W + 7;

    dec_t             dec;
    logic [XLEN-1:0]  a_c;
    logic [XLEN-1:0]  b_c;
    logic [ENT_W-1:0] entry_c;
    logic [ENT_W-1:0] head_q;
    logic [ENT_W-1:0] skid_q;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             accept;
    logic             drain;
    logic             unused_instr;

    alu_ctrl_decode u_decode (
        .opcode (in_instr[6:0]),
        .funct3 (in_instr[14:12]),
        .funct7 (in_instr[31:25]),
        .dec_c  (dec)
    );

    assign unused_instr = ^in_instr[24:15];

    // Operand muxing; shifts see only the 5-bit shamt since the ALU shifts by all of B
    always_comb begin
        case (dec.a_sel)
            A_PC:    a_c = in_pc;
            A_ZERO:  a_c = '0;
            default: a_c = in_rs1;
        endcase
        case (dec.b_sel)
            B_IMM:    b_c = in_imm;
            B_RS2_SH: b_c = XLEN'(in_rs2[4:0]);
            B_IMM_SH: b_c = XLEN'(in_imm[4:0]);
            default:  b_c = in_rs2;
        endcase
    end

    assign entry_c = {a_c, b_c, dec.code, dec.is_branch, RD_W'(in_instr[11:7]),
                      dec.reg_write, dec.illegal};

    assign accept = in_valid & in_ready;
    assign drain  = ex_valid & ex_ready;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_ONE;
                ST_ONE: begin
                    if (accept && !drain)      state_d = ST_TWO;
                    else if (!accept && drain) state_d = ST_EMPTY;
                end
                ST_TWO:   if (drain) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Handshake flags are registered alongside the state so in_ready has no path from ex_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            in_ready <= 1'b0;
            ex_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d != ST_TWO);
            ex_valid <= (state_d != ST_EMPTY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            skid_q <= '0;
        end else if (!flush) begin
            if ((state_q == ST_EMPTY && accept) || (state_q == ST_ONE && accept && drain))
                head_q <= entry_c;
            else if (state_q == ST_ONE && accept && !drain)
                skid_q <= entry_c;
            else if (state_q == ST_TWO && drain)
                head_q <= skid_q;
        end
    end

    assign {ex_a, ex_b, ex_alu_ctrl, ex_is_branch, ex_rd, ex_reg_write, ex_illegal} = head_q;

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (drain)                 perf_issued <= perf_issued + 32'd1;
            if (ex_valid && !ex_ready) perf_stall  <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed scoreboard bench for alu_issue_stage (optionally with ALU_ISSUE_PERF_EN).
module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RD_W  = 5;
    localparam int unsigned ENT_W = 2 * XLEN + RD_W + 7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc, in_rs1, in_rs2, in_imm;
    logic            flush;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_a, ex_b;
    logic [3:0]      ex_alu_ctrl;
    logic            ex_is_branch;
    logic [RD_W-1:0] ex_rd;
    logic            ex_reg_write;
    logic            ex_illegal;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0]     perf_issued, perf_stall;
`endif

    int total = 0;
    int bad   = 0;
    logic [ENT_W-1:0] sb[$];
    logic [ENT_W-1:0] pend;
    logic [ENT_W-1:0] ex_vec;
    logic [31:0]      m_issued = 0;
    logic [31:0]      m_stall  = 0;

    alu_issue_stage #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_imm       (in_imm),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_a         (ex_a),
        .ex_b         (ex_b),
        .ex_alu_ctrl  (ex_alu_ctrl),
        .ex_is_branch (ex_is_branch),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_illegal   (ex_illegal)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_issued  (perf_issued),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    assign ex_vec = {ex_a, ex_b, ex_alu_ctrl, ex_is_branch, ex_rd, ex_reg_write, ex_illegal};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ENT_W-1:0] mk(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] ctrl, input logic br,
                                            input logic [4:0] rd, input logic rw,
                                            input logic ill);
        return {a, b, ctrl, br, rd, rw, ill};
    endfunction

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [ENT_W-1:0] exp);
        in_instr = instr; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        pend     = exp;
    endtask

    task automatic check_perf(input string tag);
`ifdef ALU_ISSUE_PERF_EN
        chk({tag, " perf_issued"}, perf_issued, m_issued);
        chk({tag, " perf_stall"},  perf_stall,  m_stall);
`endif
    endtask

    // One clock of the reference buffer model, checking handshake and head contents
    task automatic tick(input string tag);
        bit acc, drn, fl;
        chk({tag, " in_ready"}, in_ready, sb.size() != 2);
        fl  = flush;
        acc = in_valid && (sb.size() != 2) && !fl;
        drn = (sb.size() != 0) && ex_ready;
        if (sb.size() != 0 && !ex_ready) m_stall++;
        if (drn) m_issued++;
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (drn) void'(sb.pop_front());
            if (acc) sb.push_back(pend);
        end
        chk({tag, " ex_valid"}, ex_valid, sb.size() != 0);
        if (sb.size() != 0) chk({tag, " head"}, ex_vec, sb[0]);
        check_perf(tag);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        in_instr = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        pend = '0;
        #1;
        chk("reset ex_valid", ex_valid, 1'b0);
        chk("reset in_ready", in_ready, 1'b0);
        chk("reset data", ex_vec, '0);
        check_perf("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset in_ready", in_ready, 1'b1);

        // Back-to-back decode coverage with EX always ready
        drive(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OP_R), 0, 5, 7, 0, mk(5, 7, 4'h0, 0, 3, 1, 0));
        tick("add");
        drive(enc(7'h20, 5'd2, 5'd1, 3'd0, 5'd4, OP_R), 0, 5, 7, 0, mk(5, 7, 4'h1, 0, 4, 1, 0));
        tick("sub");
        drive(enc(7'h20, 5'd2, 5'd1, 3'd5, 5'd5, OP_R), 0, 32'h8000_0000, 32'h23, 0,
              mk(32'h8000_0000, 3, 4'hE, 0, 5, 1, 0));
        tick("sra");
        drive(enc(7'h00, 5'd2, 5'd1, 3'd1, 5'd6, OP_R), 0, 1, 32'hFFFF_FF21, 0, mk(1, 1, 4'h6, 0, 6, 1, 0));
        tick("sll");
        drive(enc(7'h01, 5'd2, 5'd1, 3'd0, 5'd7, OP_R), 0, 9, 4, 0, mk(9, 4, 4'h0, 0, 7, 0, 1));
        tick("r_bad_funct7");
        drive(enc_i(12'hFFF, 5'd1, 3'd0, 5'd8, OP_I), 0, 10, 0, 32'hFFFF_FFFF,
              mk(10, 32'hFFFF_FFFF, 4'h0, 0, 8, 1, 0));
        tick("addi");
        drive(enc_i(12'h405, 5'd1, 3'd5, 5'd9, OP_I), 0, 32'hF000_0000, 0, 32'h405,
              mk(32'hF000_0000, 5, 4'hE, 0, 9, 1, 0));
        tick("srai");
        drive(enc_i(12'h003, 5'd1, 3'd5, 5'd10, OP_I), 0, 32'h40, 0, 32'hFFFF_FFE3,
              mk(32'h40, 3, 4'h7, 0, 10, 1, 0));
        tick("srli");
        drive(enc_i(12'h00A, 5'd1, 3'd3, 5'd11, OP_I), 0, 3, 0, 32'hA, mk(3, 32'hA, 4'hF, 0, 11, 1, 0));
        tick("sltiu");
        drive(enc_i(12'h123, 5'd0, 3'd0, 5'd12, OP_LUI), 0, 32'h55, 0, 32'h1234_5000,
              mk(0, 32'h1234_5000, 4'h0, 0, 12, 1, 0));
        tick("lui");
        drive(enc_i(12'h002, 5'd0, 3'd0, 5'd13, OP_AUIPC), 32'h100, 32'h55, 0, 32'h2000,
              mk(32'h100, 32'h2000, 4'h0, 0, 13, 1, 0));
        tick("auipc");
        drive(enc_i(12'h010, 5'd1, 3'd2, 5'd14, OP_LOAD), 0, 32'h1000, 0, 32'h10,
              mk(32'h1000, 32'h10, 4'h0, 0, 14, 1, 0));
        tick("lw");
        drive(enc(7'h00, 5'd2, 5'd1, 3'd2, 5'd0, OP_STORE), 0, 32'h2000, 32'hDEAD, 32'h8,
              mk(32'h2000, 32'h8, 4'h0, 0, 0, 0, 0));
        tick("sw");
        drive(enc(7'h00, 5'd2, 5'd1, 3'd7, 5'd0, OP_BRANCH), 0, 32'hFFFF_FFFF, 1, 0,
              mk(32'hFFFF_FFFF, 1, 4'hB, 1, 0, 0, 0));
        tick("bgeu");
        drive(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, OP_BRANCH), 0, 4, 4, 0, mk(4, 4, 4'hC, 1, 0, 0, 0));
        tick("beq");
        drive(enc(7'h00, 5'd2, 5'd1, 3'd4, 5'd0, OP_BRANCH), 0, 6, 8, 0, mk(6, 8, 4'h8, 1, 0, 0, 0));
        tick("blt");
        drive(enc(7'h00, 5'd2, 5'd1, 3'd2, 5'd0, OP_BRANCH), 0, 6, 8, 0, mk(6, 8, 4'h0, 0, 0, 0, 1));
        tick("branch_f3_010");
        drive(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h7F), 0, 1, 2, 0, mk(1, 2, 4'h0, 0, 0, 0, 1));
        tick("unknown_op");
        in_valid = 1'b0;
        tick("drain_last");
        tick("idle");

        // Backpressure: two accepted, third held off, then in-order drain
        ex_ready = 1'b0;
        drive(enc(7'h00, 5'd2, 5'd1, 3'd4, 5'd1, OP_R), 0, 32'hF0, 32'h0F, 0, mk(32'hF0, 32'h0F, 4'h4, 0, 1, 1, 0));
        tick("bp_first");
        drive(enc(7'h00, 5'd2, 5'd1, 3'd6, 5'd2, OP_R), 0, 32'hA0, 32'h0A, 0, mk(32'hA0, 32'h0A, 4'h3, 0, 2, 1, 0));
        tick("bp_second");
        drive(enc(7'h00, 5'd2, 5'd1, 3'd7, 5'd3, OP_R), 0, 32'hC0, 32'h0C, 0, mk(32'hC0, 32'h0C, 4'h2, 0, 3, 1, 0));
        tick("bp_third_blocked");
        tick("bp_hold");
        ex_ready = 1'b1;
        in_valid = 1'b0;
        tick("bp_drain1");
        tick("bp_drain2");
        tick("bp_empty");

        // Flush while full, coincident with a new instruction
        ex_ready = 1'b0;
        drive(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd4, OP_R), 0, 1, 1, 0, mk(1, 1, 4'h0, 0, 4, 1, 0));
        tick("fl_fill1");
        drive(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd5, OP_R), 0, 2, 2, 0, mk(2, 2, 4'h0, 0, 5, 1, 0));
        tick("fl_fill2");
        drive(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd6, OP_R), 0, 3, 3, 0, mk(3, 3, 4'h0, 0, 6, 1, 0));
        flush = 1'b1;
        tick("flush");
        flush    = 1'b0;
        in_valid = 1'b0;
        tick("post_flush");

        // Asynchronous reset with one entry held
        drive(enc(7'h00, 5'd2, 5'd1, 3'd3, 5'd7, OP_R), 0, 1, 2, 0, mk(1, 2, 4'hF, 0, 7, 1, 0));
        tick("rst_fill");
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst ex_valid", ex_valid, 1'b0);
        chk("async_rst in_ready", in_ready, 1'b0);
        chk("async_rst data", ex_vec, '0);
        sb.delete();
        m_issued = 0;
        m_stall  = 0;
        check_perf("async_rst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release in_ready", in_ready, 1'b1);
        chk("rst_release ex_valid", ex_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
